// File: rtl/pc_sequencer_rv32i.sv
// RV32I fetch sequencer: holds the next fetch PC, issues one instruction-memory
// request at a time, and presents the returned word to decode with its address.
module pc_sequencer_rv32i #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ack,
  input  logic        if_rvalid,
  input  logic [31:0] if_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic [1:0]  state
);

  // Handshakes: a fetch is accepted when if_req && if_ack; an instruction
  // moves to decode when inst_valid && inst_ready. if_rvalid is honoured
  // only in WAIT.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    HOLD = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cap_q, cap_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        discard_q, discard_d;
  state_t      resume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      cap_q     <= 32'h0;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cap_q     <= cap_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cap_d     = cap_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    discard_d = discard_q;
    resume    = run ? REQ : IDLE;

    case (state_q)
      IDLE: begin
        if (run) state_d = REQ;
      end
      REQ: begin
        if (if_ack) begin
          state_d = WAIT;
          cap_d   = pc_q;
          pc_d    = pc_q + 32'd4;
          // The in-flight word belongs to the old path once redirected.
          if (redirect) discard_d = 1'b1;
        end
      end
      WAIT: begin
        if (if_rvalid) begin
          if (discard_q || redirect) begin
            discard_d = 1'b0;
            state_d   = resume;
          end else begin
            inst_d    = if_rdata;
            inst_pc_d = cap_q;
            state_d   = HOLD;
          end
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || inst_ready) state_d = resume;
      end
      default: state_d = IDLE;
    endcase

    // Redirect wins over the sequential +4 step.
    if (redirect) pc_d = {redirect_pc[31:2], 2'b00};
  end

  assign if_req     = (state_q == REQ);
  assign if_addr    = pc_q;
  assign inst_valid = (state_q == HOLD) && !redirect;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign pc         = pc_q;
  assign state      = state_q;

endmodule

// File: doc/pc_sequencer_rv32i.md
PC_SEQUENCER_RV32I -- requirements
Module: pc_sequencer_rv32i

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 One clock; reset is asynchronous and active-low: clock  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 run  in  1  fetch enable; low = stop fetching at the next instruction boundary.
REQ-004 redirect  in  1  taken branch/jump pulse from brancher stage.
REQ-005 redirect_pc  in  32  new PC (brancher PCin value).
REQ-006 if_req  out  1  instruction-memory request valid.
REQ-007 if_addr  out  32  fetch address.
REQ-008 if_ack  in  1  memory accepts request.
REQ-009 if_rvalid  in  1  read data valid.
REQ-010 if_rdata  in  32  instruction word.
REQ-011 inst_valid  out  1  instruction available to decode.
REQ-012 inst  out  32  held instruction.
REQ-013 inst_pc  out  32  address of held instruction.
REQ-014 inst_ready  in  1  decode consumes instruction.
REQ-015 pc  out  32  next fetch address register.
REQ-016 state  out  2  FSM state: IDLE=00, REQ=01, WAIT=10, HOLD=11.

Function
REQ-017 FSM SHALL have exactly four states: IDLE, REQ, WAIT, HOLD; at most one fetch outstanding.
REQ-018 IDLE: run=1 -> REQ next cycle; run=0 -> stay.
REQ-019 REQ: if_req=1, if_addr=pc; if_ack=1 -> WAIT, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), captured address stored for inst_pc.
REQ-020 if_req SHALL be high only in REQ; if_addr SHALL stay stable while if_req=1 and if_ack=0, except on redirect.
REQ-021 WAIT: if_rvalid=1 -> inst<=if_rdata, inst_pc<=captured address, HOLD next cycle (inst_valid one cycle after rvalid).
REQ-022 HOLD: inst_valid=1; inst_ready=1 -> REQ if run=1 else IDLE; inst/inst_pc SHALL stay stable while inst_ready=0.
REQ-023 inst_valid SHALL equal (state==HOLD) AND NOT redirect; a HOLD cycle with redirect=1 is never a transfer.
REQ-024 redirect in any state: pc<=redirect_pc with bits [1:0] forced to 00; redirect takes priority over +4 increment.
REQ-025 redirect in IDLE: pc updated, state unchanged (still gated by run).
REQ-026 redirect in REQ, if_ack=0: pc updated, stay REQ, if_addr shows new pc next cycle.
REQ-027 redirect in REQ with if_ack=1: pc<=redirect_pc, go WAIT with discard flag set.
REQ-028 redirect in WAIT: pc updated, discard flag set; response arriving (same or later cycle) while discard=1 SHALL be dropped, discard cleared, state -> REQ (or IDLE if run=0).
REQ-029 redirect in HOLD (with or without inst_ready): held instruction dropped, state -> REQ (or IDLE if run=0).
REQ-030 run=0 SHALL NOT abort an outstanding fetch; block finishes REQ/WAIT/HOLD and then enters IDLE.
REQ-031 if_rvalid outside WAIT SHALL be ignored; if_ack outside REQ SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL immediately (asynchronously) force: state=IDLE, pc=RESET_PC, if_req=0, inst_valid=0, inst=0, inst_pc=0, discard=0.
REQ-033 Reset asserted mid-fetch SHALL abandon the fetch; late if_rvalid after reset release in IDLE/REQ is ignored.
REQ-034 After rst_n rises, first if_req SHALL appear no earlier than the cycle after run is sampled high in IDLE.

Verification
REQ-035 Reset, run=1, if_ack immediate, rvalid 1 cycle later with 32'h0000_0013 -> if_addr=0, inst_valid with inst=32'h13, inst_pc=0; after inst_ready, if_addr=4.
REQ-036 Memory withholds if_ack 3 cycles -> if_req held high, if_addr constant 0, pc unchanged until ack.
REQ-037 Redirect to 32'h0000_0102 during WAIT, rvalid arrives later -> response dropped, inst_valid stays 0, next if_addr=32'h0000_0100.
REQ-038 HOLD with inst_ready=1 and redirect=1 same cycle to 32'h80 -> inst_valid=0 that cycle, next if_addr=32'h80.
REQ-039 pc=32'hFFFF_FFFC fetch acked -> pc=0, inst_pc=32'hFFFF_FFFC.
REQ-040 rst_n low during WAIT -> state=IDLE and inst_valid=0 asynchronously; subsequent stray if_rvalid produces no inst_valid.
